// File: rtl/ifetch_unit.sv
// Instruction fetch unit: takes a PC, issues one instruction-memory read, and holds the
// returned word for decode. Misaligned PCs bypass memory and deliver a faulting bubble.
module ifetch_unit #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_valid,
    output logic          pc_ready,
    output logic [AW-1:0] mem_req_addr,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    input  logic [31:0]   mem_rsp_data,
    input  logic          mem_rsp_valid,
    output logic [31:0]   instr_out,
    output logic [AW-1:0] instr_pc,
    output logic          instr_fault,
    output logic          instr_valid,
    input  logic          instr_ready,
    input  logic          flush,
    output logic [31:0]   fetch_count
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          fault_q, fault_d;
    logic [31:0]   fetch_count_q, fetch_count_d;
    logic          pc_accept;

    assign pc_ready      = !flush && ((state_q == StIdle) || ((state_q == StHold) && instr_ready));
    assign pc_accept     = pc_valid && pc_ready;
    assign mem_req_valid = (state_q == StReq);
    assign mem_req_addr  = pc_q;
    assign instr_valid   = (state_q == StHold);
    assign instr_out     = instr_q;
    assign instr_pc      = pc_q;
    assign instr_fault   = fault_q;
    assign fetch_count   = fetch_count_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StReq: begin
                if (flush) begin
                    // A request already handshaken still owes us a response to swallow.
                    state_d = mem_req_ready ? StDrain : StIdle;
                end else if (mem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (flush) begin
                    state_d = mem_rsp_valid ? StIdle : StDrain;
                end else if (mem_rsp_valid) begin
                    instr_d = mem_rsp_data;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (instr_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = StIdle;
                end
            end
            StDrain: begin
                if (mem_rsp_valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // pc_ready already excludes flush and busy states, so accept overrides the above.
        if (pc_accept) begin
            pc_d = pc_in;
            if (pc_in[1:0] != 2'b00) begin
                fault_d = 1'b1;
                instr_d = 32'd0;
                state_d = StHold;
            end else begin
                fault_d = 1'b0;
                state_d = StReq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            instr_q       <= 32'd0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus randomized traffic, all checked against a
// transaction-level model of what the fetch unit owes memory and decode each cycle.
module tb_ifetch_unit;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic          pc_valid = 1'b0;
    logic          pc_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [31:0]   mem_rsp_data = 32'd0;
    logic          mem_rsp_valid = 1'b0;
    logic [31:0]   instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_fault;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          flush = 1'b0;
    logic [31:0]   fetch_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifetch_unit #(.AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_valid     (pc_valid),
        .pc_ready     (pc_ready),
        .mem_req_addr (mem_req_addr),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_data (mem_rsp_data),
        .mem_rsp_valid(mem_rsp_valid),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .instr_fault  (instr_fault),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .flush        (flush),
        .fetch_count  (fetch_count)
    );

    // Model: what is owed to memory (a request, a response to await or to discard) and to decode.
    bit          m_req, m_await, m_discard, m_have, m_fault;
    logic [31:0] m_pc, m_instr, m_count;
    bit          rand_mode = 1'b0;
    bit          mem_out = 1'b0;
    int          mem_delay = 0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] held;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h00500093;
    endfunction

    function automatic bit m_idle();
        return !(m_req || m_await || m_discard || m_have);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_await = 0; m_discard = 0; m_have = 0; m_fault = 0;
        m_pc = 0; m_instr = 0; m_count = 0;
    endtask

    // Called at a negedge with inputs applied; checks, takes the edge, returns at next negedge.
    task automatic step(input bit do_check);
        logic exp_ready;
        bit   hs;
        #1;
        exp_ready = !flush && (m_idle() || (m_have && instr_ready));
        if (do_check) begin
            chk("pc_ready", {31'd0, pc_ready}, {31'd0, exp_ready});
            chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, m_req});
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
            chk("fetch_count", fetch_count, m_count);
            if (m_req) chk("mem_req_addr", mem_req_addr, m_pc);
            if (m_have) begin
                chk("instr_out", instr_out, m_instr);
                chk("instr_pc", instr_pc, m_pc);
                chk("instr_fault", {31'd0, instr_fault}, {31'd0, m_fault});
                if (rand_mode && !m_fault) chk("instr_vs_mem", instr_out, mem_word(instr_pc));
            end
        end
        hs = m_req && mem_req_ready && !flush;
        if (m_req && mem_req_ready && flush) hs = 1'b1;
        @(posedge clk);
        if (!reset) begin
            model_reset();
            mem_out = 0;
        end else begin
            if (mem_rsp_valid) mem_out = 0;
            else if (mem_delay > 0) mem_delay--;
            if (hs) begin
                mem_out = 1; mem_addr = m_pc; mem_delay = $urandom_range(0, 2);
            end
            if (m_discard) begin
                if (mem_rsp_valid) m_discard = 0;
            end else if (flush) begin
                if (m_req) begin m_req = 0; m_discard = mem_req_ready; end
                else if (m_await) begin m_await = 0; m_discard = !mem_rsp_valid; end
                else m_have = 0;
            end else begin
                if (m_req) begin
                    if (mem_req_ready) begin m_req = 0; m_await = 1; end
                end else if (m_await) begin
                    if (mem_rsp_valid) begin m_await = 0; m_have = 1; m_instr = mem_rsp_data; end
                end else if (m_have && instr_ready) begin
                    m_have = 0; m_count = m_count + 32'd1;
                end
                if (pc_valid && exp_ready) begin
                    m_pc = pc_in;
                    if (pc_in[1:0] != 2'b00) begin m_have = 1; m_fault = 1; m_instr = 0; end
                    else begin m_req = 1; m_fault = 0; end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        reset = 1; pc_valid = 0; flush = 0; mem_req_ready = 0; mem_rsp_valid = 0;
        instr_ready = 0; mem_rsp_data = 32'd0;
    endtask

    task automatic do_reset();
        reset = 0; step(1); reset = 1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        reset = 0; step(0); step(0);
        quiet();
        #1;
        chk("rst_pc_ready", {31'd0, pc_ready}, 32'd1);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_fault", {31'd0, instr_fault}, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);

        // Basic fetch
        pc_in = 32'h0; pc_valid = 1; mem_req_ready = 1; step(1);
        pc_valid = 0; step(1);
        mem_rsp_valid = 1; mem_rsp_data = 32'h00500093; step(1);
        mem_rsp_valid = 0; instr_ready = 1; #1;
        chk("basic_valid", {31'd0, instr_valid}, 32'd1);
        chk("basic_instr", instr_out, 32'h00500093);
        chk("basic_pc", instr_pc, 32'h0);
        step(1);
        chk("basic_count", fetch_count, 32'd1);

        // Sequential stream, no bubble between delivery and the next request
        do_reset();
        instr_ready = 1; mem_req_ready = 1;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'(i * 4); pc_valid = 1; mem_rsp_valid = 0; #1;
            chk("stream_ready", {31'd0, pc_ready}, 32'd1);
            if (i > 0) chk("stream_pc", instr_pc, 32'((i - 1) * 4));
            step(1);
            pc_valid = 0; step(1);
            chk("stream_req", {31'd0, mem_req_valid}, 32'd0);
            mem_rsp_valid = 1; mem_rsp_data = 32'h1000 + 32'(i); step(1);
        end
        mem_rsp_valid = 0; #1;
        chk("stream_last_pc", instr_pc, 32'h8);
        chk("stream_last_instr", instr_out, 32'h1002);
        step(1);
        chk("stream_count", fetch_count, 32'd3);

        // Misaligned PC
        pc_in = 32'h6; pc_valid = 1; instr_ready = 0; step(1);
        pc_valid = 0; #1;
        chk("mis_req", {31'd0, mem_req_valid}, 32'd0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd1);
        chk("mis_fault", {31'd0, instr_fault}, 32'd1);
        chk("mis_instr", instr_out, 32'd0);
        chk("mis_pc", instr_pc, 32'h6);
        instr_ready = 1; step(1);

        // Flush while waiting for the response
        pc_in = 32'h10; pc_valid = 1; step(1);
        pc_valid = 0; step(1);
        flush = 1; step(1);
        flush = 0; #1;
        chk("drain_ready", {31'd0, pc_ready}, 32'd0);
        mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF; step(1);
        mem_rsp_valid = 0; #1;
        chk("drain_valid", {31'd0, instr_valid}, 32'd0);
        chk("drain_idle", {31'd0, pc_ready}, 32'd1);
        pc_in = 32'h40; pc_valid = 1; step(1);
        pc_valid = 0; step(1);
        mem_rsp_valid = 1; mem_rsp_data = 32'h00000013; step(1);
        mem_rsp_valid = 0; #1;
        chk("after_flush_instr", instr_out, 32'h13);
        chk("after_flush_pc", instr_pc, 32'h40);
        step(1);

        // Memory backpressure then decode stall
        pc_in = 32'h20; pc_valid = 1; step(1);
        pc_valid = 0; mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("bp_addr", mem_req_addr, 32'h20); step(1);
        end
        mem_req_ready = 1; step(1);
        mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE0001; instr_ready = 0; step(1);
        mem_rsp_valid = 0; pc_valid = 1; pc_in = 32'h24;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_instr", instr_out, 32'hCAFE0001);
            chk("stall_ready", {31'd0, pc_ready}, 32'd0);
            step(1);
        end
        pc_valid = 0; instr_ready = 1; step(1);

        // Flush in REQ with handshake, flush in HOLD with instr_ready, reset mid-WAIT
        pc_in = 32'h30; pc_valid = 1; step(1);
        pc_valid = 0; flush = 1; step(1);
        flush = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h11111111; step(1);
        mem_rsp_valid = 0; pc_in = 32'h3; pc_valid = 1; step(1);
        pc_valid = 0; flush = 1; instr_ready = 1; step(1);
        flush = 0; #1; chk("flush_hold_count", fetch_count, m_count);
        pc_in = 32'h50; pc_valid = 1; step(1);
        pc_valid = 0; step(1);
        do_reset();
        mem_rsp_valid = 1; mem_rsp_data = 32'h22222222; step(1);
        mem_rsp_valid = 0; #1; chk("late_rsp_valid", {31'd0, instr_valid}, 32'd0);

        // Counter wrap
        force dut.fetch_count_q = 32'hFFFFFFFF;
        #1;
        release dut.fetch_count_q;
        m_count = 32'hFFFFFFFF;
        pc_in = 32'h2; pc_valid = 1; instr_ready = 0; step(1);
        pc_valid = 0; #1;
        chk("wrap_pre", fetch_count, 32'hFFFFFFFF);
        instr_ready = 1; step(1);
        chk("wrap_post", fetch_count, 32'h0);

        // Randomized traffic
        quiet();
        do_reset();
        rand_mode = 1;
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 99) != 0);
            flush = ($urandom_range(0, 15) == 0);
            pc_valid = ($urandom_range(0, 3) != 0);
            pc_in = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0) pc_in = pc_in | 32'($urandom_range(1, 3));
            instr_ready = ($urandom_range(0, 2) != 0);
            mem_req_ready = ($urandom_range(0, 2) != 0);
            if (mem_out && mem_delay == 0) begin
                mem_rsp_valid = 1; mem_rsp_data = mem_word(mem_addr);
            end else begin
                mem_rsp_valid = 0; mem_rsp_data = $urandom;
            end
            step(1);
        end
        held = 32'd0;
        if (held == 32'd0) ;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter AW, default 32, address/PC width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports pc_in  input  AW  fetch address from PC block; pc_valid  input  1; pc_ready  output  1.
REQ-005 SHALL have ports mem_req_addr  output  AW; mem_req_valid  output  1; mem_req_ready  input  1  instruction-memory read request.
REQ-006 SHALL have ports mem_rsp_data  input  32; mem_rsp_valid  input  1  read response, in order, at most one outstanding.
REQ-007 SHALL have ports instr_out  output  32; instr_pc  output  AW; instr_fault  output  1; instr_valid  output  1; instr_ready  input  1  toward decode.
REQ-008 SHALL have port flush  input  1  discard in-flight fetch (branch/jump redirect).
REQ-009 SHALL have port fetch_count  output  32  instructions delivered since reset.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, DRAIN; state register only.
REQ-011 SHALL assert pc_ready when flush=0 and (state=IDLE or (state=HOLD and instr_ready=1)).
REQ-012 SHALL, on pc_valid&pc_ready, latch pc_in into pc_q; pc_in[1:0]!=0 -> HOLD with fault_q=1, instr_q=0, no memory request; else -> REQ with fault_q=0.
REQ-013 SHALL in REQ drive mem_req_valid=1, mem_req_addr=pc_q, holding both stable until mem_req_ready=1, then -> WAIT.
REQ-014 SHALL in WAIT, on mem_rsp_valid=1, latch mem_rsp_data into instr_q and -> HOLD; mem_rsp_valid in any non-WAIT/DRAIN state SHALL be ignored.
REQ-015 SHALL in HOLD drive instr_valid=1, instr_out=instr_q, instr_pc=pc_q, instr_fault=fault_q, all stable until instr_ready=1.
REQ-016 SHALL on HOLD with instr_ready=1: increment fetch_count by 1 (mod 2^32, wraps FFFFFFFF->0); -> per REQ-012 if new PC accepted same cycle, else -> IDLE.
REQ-017 SHALL give latency: PC accept at edge N, mem_req_valid from cycle N+1, instr_valid one cycle after response edge; back-to-back delivery with zero bubble between HOLD and next REQ.
REQ-018 SHALL give flush priority over every other event in the same cycle; pc_ready=0 while flush=1.
REQ-019 SHALL on flush: IDLE/HOLD -> IDLE, held instruction dropped, fetch_count unchanged even if instr_ready=1.
REQ-020 SHALL on flush in REQ: if mem_req_ready=1 same cycle -> DRAIN, else -> IDLE with mem_req_valid withdrawn next cycle.
REQ-021 SHALL on flush in WAIT: if mem_rsp_valid=1 same cycle -> IDLE (response discarded), else -> DRAIN.
REQ-022 SHALL in DRAIN keep pc_ready=0, instr_valid=0, discard next mem_rsp_valid data, then -> IDLE; further flush in DRAIN has no effect.
REQ-023 SHALL deassert instr_valid and mem_req_valid in all states other than HOLD and REQ respectively.

Reset
REQ-024 SHALL when reset=0 at a rising edge: state=IDLE, pc_q=0, instr_q=0, fault_q=0, fetch_count=0.
REQ-025 SHALL after reset present instr_valid=0, mem_req_valid=0, mem_req_addr=0, instr_out=0, instr_pc=0, instr_fault=0, pc_ready=1 (flush=0).
REQ-026 SHALL on reset mid-operation (REQ/WAIT/DRAIN/HOLD) abandon the transaction; late mem_rsp_valid after reset SHALL be ignored in IDLE.

Verification
REQ-027 SHALL cover basic fetch: reset, pc_in=0x00000000 valid, mem_req_ready=1, rsp 0x00500093 one cycle later -> instr_valid with instr_out=0x00500093, instr_pc=0, fetch_count=1 after accept.
REQ-028 SHALL cover sequential stream: PCs 0x0,0x4,0x8 with instr_ready tied 1, memory 1-cycle latency -> three instructions in order, instr_pc 0x0/0x4/0x8, fetch_count=3, no HOLD->IDLE bubble.
REQ-029 SHALL cover misaligned: pc_in=0x00000006 -> no mem_req_valid, instr_valid=1, instr_fault=1, instr_out=0, instr_pc=0x6.
REQ-030 SHALL cover flush in WAIT: request 0x10 accepted, flush before response -> DRAIN, response 0xDEADBEEF discarded, instr_valid stays 0, next PC 0x40 fetched normally.
REQ-031 SHALL cover backpressure and stall: mem_req_ready=0 for 3 cycles -> mem_req_addr stable; instr_ready=0 for 4 cycles -> instr_out stable, pc_ready=0.
REQ-032 SHALL cover wrap: fetch_count forced/driven to 0xFFFFFFFF, one delivery -> fetch_count=0x00000000.
